// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the transmitter and receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;
    localparam int unsigned DefaultCyclesPerBit = 868;
    typedef logic [7:0] UartDataT;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser (reset high) with a falling-edge strobe
module uart_rx_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d,
    output logic q,
    output logic fall
);
    logic [2:0] ff;
    always_ff @(posedge clk_i) begin
        if (reset_i) ff <= 3'b111;
        else         ff <= {ff[1:0], d};
    end
    assign q    = ff[1];
    assign fall = ff[2] & ~ff[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and a valid/ready output port
module uart_rx import uart_pkg::*; #(
    parameter int unsigned DefaultCyclesPerBit = uart_pkg::DefaultCyclesPerBit,
    parameter int          DataBits            = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [31:0]         prescaler,
    input  logic                rx,
    output logic [DataBits-1:0] data,
    output logic                valid,
    input  logic                ready,
    output logic                frame_err,
    output logic                overrun
);
    localparam int IW = $clog2(DataBits);
    uart_rx_state_t state, state_next;
    logic rx_s, fall;
    logic [31:0] cpb_q, cnt;
    logic [IW-1:0] idx;
    logic [DataBits-1:0] shift;
    logic commit_q, half_hit, bit_hit, last_bit;
    logic leave_idle, shift_en, stop_ok, stop_bad;

    uart_rx_sync u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d       (rx),
        .q       (rx_s),
        .fall    (fall)
    );

    assign half_hit = cnt == (cpb_q >> 1) - 32'd1;
    assign bit_hit  = cnt == cpb_q - 32'd1;
    assign last_bit = idx == IW'(DataBits - 1);

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = fall ? START : IDLE;
            START:     state_next = half_hit ? (rx_s ? IDLE : DATA) : START;
            DATA:      state_next = (bit_hit && last_bit) ? STOP : DATA;
            STOP:      state_next = bit_hit ? (rx_s ? IDLE : WAIT_IDLE) : STOP;
            WAIT_IDLE: state_next = rx_s ? IDLE : WAIT_IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        leave_idle = state == IDLE && fall;
        shift_en   = state == DATA && bit_hit;
        stop_ok    = state == STOP && bit_hit && rx_s;
        stop_bad   = state == STOP && bit_hit && !rx_s;
    end

    // cpb_q is frozen for the whole frame, so prescaler writes mid-frame are ignored
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cpb_q     <= '0;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            commit_q  <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (leave_idle) cpb_q <= (prescaler == 32'd0) ? 32'(DefaultCyclesPerBit) : prescaler;
            cnt       <= (state == IDLE || state_next != state || bit_hit) ? '0 : cnt + 32'd1;
            idx       <= (state == START) ? '0 : shift_en ? idx + 1'b1 : idx;
            if (shift_en) shift <= {rx_s, shift[DataBits-1:1]};
            commit_q  <= stop_ok;
            frame_err <= stop_bad;
            overrun   <= commit_q && valid && !ready;
            if (commit_q) data <= shift;
            valid     <= commit_q || (valid && !ready);
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx against a frame-level model
module tb_uart_rx;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] prescaler = 32'd16;
    logic        rx = 1'b1;
    logic        ready = 1'b1;
    logic [7:0]  data;
    logic        valid, frame_err, overrun;

    int n_checks = 0, n_fail = 0;
    int exp_fe = 0, exp_ov = 0, fe_seen = 0, ov_seen = 0, vcyc = 0, rises = 0;
    logic [7:0] exp_q[$];
    logic [7:0] first_data = 8'h00;
    logic valid_d = 1'b0;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .prescaler (prescaler),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a good frame yields its byte; an unaccepted older byte is replaced (overrun)
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) exp_fe++;
        else begin
            if (!ready && exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                exp_ov++;
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop = 1'b1, input int bc = 16,
                        input int rst_bit = -1, input int psc_bit = -1, input logic [31:0] psc_new = 0);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            if (i == 9 && rst_bit < 0) model_frame(b, stop);
            if (i == psc_bit) prescaler = psc_new;
            for (int c = 0; c < bc; c++) begin
                reset_i = (i == rst_bit && c == bc / 2);
                wait_cyc(1);
            end
        end
        reset_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() > 0 && k < 5000) begin
            wait_cyc(1);
            k++;
        end
        check(name, exp_q.size(), 0);
        wait_cyc(4);
        check({name, "_fe"}, fe_seen, exp_fe);
        check({name, "_ov"}, ov_seen, exp_ov);
    endtask

    always @(negedge clk) begin
        if (!reset_i) begin
            if (valid) vcyc++;
            if (valid && !valid_d) begin
                rises++;
                first_data = data;
            end
            valid_d = valid;
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, none expected", data);
                end else check("rx_byte", data, exp_q.pop_front());
            end
        end else valid_d = 1'b0;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        wait_cyc(3);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        reset_i = 1'b0;
        wait_cyc(20);

        vcyc = 0;
        send(8'hA5);
        wait_cyc(16);
        drain("a5");
        check("a5_valid_cycles", vcyc, 1);

        ready = 1'b0;
        rises = 0;
        send(8'h3C);
        send(8'hC3);
        wait_cyc(32);
        check("ovr_rises", rises, 1);
        check("ovr_first", first_data, 8'h3C);
        check("ovr_valid_held", valid, 1);
        check("ovr_data", data, 8'hC3);
        ready = 1'b1;
        drain("ovr");

        vcyc = 0;
        rx = 1'b0;
        wait_cyc(4);
        rx = 1'b1;
        wait_cyc(40);
        check("glitch_valid", vcyc, 0);
        check("glitch_fe", fe_seen, exp_fe);

        send(8'h55, 1'b0);
        wait_cyc(40);
        rx = 1'b1;
        wait_cyc(32);
        check("ferr_valid", vcyc, 0);
        send(8'h0F);
        wait_cyc(16);
        drain("ferr");

        send(8'hFF, 1'b1, 16, 5);
        wait_cyc(32);
        send(8'h81);
        wait_cyc(16);
        drain("rst_mid");

        for (int n = 0; n < 20; n++) begin
            send(8'($urandom));
            wait_cyc($urandom_range(0, 3) * 16);
        end
        wait_cyc(16);
        drain("random");

        prescaler = 32'd0;
        wait_cyc(4);
        send(8'h00, 1'b1, 868);
        wait_cyc(868);
        drain("psc0");
        send(8'h5A, 1'b1, 868, -1, 3, 32'd16);
        wait_cyc(868);
        drain("psc_change");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
